fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage. Generates the PC and drives reads into a synchronous instruction memory.
- Buffers returned 24-bit instruction words and presents them, with their PC, to the decode stage over a valid/ready handshake.
- Redirects on taken branches and stops fetching after a HALT opcode.
- Producer end of the instruction/PC interface that the decode stage consumes.

Parameters:
- WIDTH, 32, PC/data width
- INSTRUCTIONWIDTH, 24, instruction word width
- OPCODEWIDTH, 4, opcode field width (instruction[23:20])
- RESETPC, 0, first fetch address after reset
- PCSTEP, 4, sequential PC increment
- PCOFFSET, 8, added to an instruction's own address to form the PC value handed to decode

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- imemAddress  out  WIDTH  read address (= pcFetch register)
- imemReadEnable  out  1  read issued this cycle
- imemData  in  INSTRUCTIONWIDTH  read data, valid the cycle after the issue
- decodeReady  in  1  decode accepts the head instruction this cycle
- instrValid  out  1  head instruction valid
- instruction  out  INSTRUCTIONWIDTH  head instruction word
- PC  out  WIDTH  head instruction address + PCOFFSET
- branchTaken  in  1  redirect request
- branchTarget  in  WIDTH  redirect address
- halted  out  1  fetch FSM is in HALTED

Behaviour:
- State: pcFetch, respValid/respPC (read in flight), a 2-entry FIFO of {instruction, address}, and an FSM with states FETCH and HALTED.
- Reset (reset=0, async):
  - pcFetch=RESETPC, respValid=0, FIFO empty, FSM=FETCH.
  - imemReadEnable=0, instrValid=0, instruction=0, PC=0, halted=0.
  - Reset mid-operation discards everything immediately.
- Pop: pop = instrValid & decodeReady. instruction and PC always show the FIFO head; both are 0 when empty.
- Issue: imemReadEnable = (FSM==FETCH) & !branchTaken & (count + respValid - pop < 2).
  - On issue: respValid<=1, respPC<=pcFetch, pcFetch<=pcFetch+PCSTEP (modulo 2^WIDTH, wraps silently).
  - No issue: respValid<=0.
- Latency: read issued in cycle n, imemData sampled in n+1, instrValid high in n+2.
- Throughput: 1 instruction/cycle while decodeReady=1.
- Stall: decodeReady=0 leaves head and PC stable. The in-flight response still lands in the FIFO, and issue stops once the FIFO would be full. No response is ever dropped or overwritten.
- Write: a response is pushed when respValid=1, FSM==FETCH and no redirect occurs in that cycle.
  - If the pushed word has opcode (instruction[23:20]) == HALTOPCODE, the FSM goes to HALTED next cycle.
  - The HALT word itself is pushed and delivered.
  - A response arriving while in HALTED is discarded.
- HALTED: no issue, halted=1. Instructions already in the FIFO still drain normally. Only branchTaken or reset leaves HALTED.
- Redirect (branchTaken=1), which has priority over everything:
  - pcFetch<=branchTarget; FIFO cleared; respValid<=0 (in-flight read squashed); FSM<=FETCH.
  - No issue in the redirect cycle; the target is issued next cycle.
  - Redirect in cycle t gives instrValid at t+3 with PC = branchTarget + PCOFFSET.
  - Redirect together with pop: the pop is irrelevant, the FIFO is still cleared.
- FIFO full (count=2) with no pop: no issue and no overflow, guaranteed by the issue rule.

Decomposition:
- Package fetch_pkg:
  - HALTOPCODE = 4'hF
  - OPCODE_MSB/LSB field constants (23/20)
  - typedef fetch_entry_t {instruction, address}
  - typedef enum fetch_state_t {FETCH, HALTED}
- One sub-module, fetch_buffer: 2-entry FIFO with push, pop, clear, count, head, and the same async active-low reset.

Test Plan:
1. Reset release, RESETPC=0, memory word at address a = a/4 (opcode 0), decodeReady=1 → imemAddress 0,4,8,… one per cycle; instrValid first high 2 cycles after release; PC sequence 8,12,16; one instruction per cycle.
2. Steady stream, decodeReady=0 for 5 cycles → FIFO fills to 2, imemReadEnable=0; head stays address 0x10 (PC 0x18); after release the next words arrive in order with no gap, loss or duplicate.
3. branchTaken=1 with branchTarget=0x100 while FIFO holds 2 entries and a read is in flight → instrValid=0 next cycle; imemAddress=0x100 with imemReadEnable=1 one cycle later; PC=0x108 valid at t+3; no stale words delivered.
4. Word 0xF00000 at address 0x20 → delivered with PC 0x28; halted=1; no further imemReadEnable; the word fetched at 0x24 is never delivered; branchTaken to 0x40 clears halted and fetch resumes at 0x40.
5. reset driven low mid-stream with FIFO full → outputs go to reset values asynchronously; after release fetch restarts at RESETPC.
6. pcFetch=0xFFFFFFFC, PCSTEP=4 → next imemAddress=0x00000000 (wrap); delivered PC = 0x00000004 for the word at 0xFFFFFFFC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the opcode field location, HALT encoding, buffer entry and FSM state.
package fetch_pkg;

    localparam int P_WIDTH      = 32;
    localparam int P_IWIDTH     = 24;
    localparam int OPCODE_MSB   = 23;
    localparam int OPCODE_LSB   = 20;

    localparam logic [3:0] HALTOPCODE = 4'hF;

    typedef struct packed {
        logic [P_IWIDTH-1:0] instruction;
        logic [P_WIDTH-1:0]  address;
    } fetch_entry_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {instruction, address} pairs.
// Clear has priority over push and pop.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rdPtr;
    logic         r_wrPtr;
    logic [1:0]   r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (i_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, synchronous imem reads, 2-deep
// buffering toward decode, branch redirect and HALT stop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          WIDTH            = 32,
    parameter int          INSTRUCTIONWIDTH = 24,
    parameter int          OPCODEWIDTH      = 4,
    parameter int unsigned RESETPC          = 0,
    parameter int unsigned PCSTEP           = 4,
    parameter int unsigned PCOFFSET         = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic [WIDTH-1:0]            imemAddress,
    output logic                        imemReadEnable,
    input  logic [INSTRUCTIONWIDTH-1:0] imemData,
    input  logic                        decodeReady,
    output logic                        instrValid,
    output logic [INSTRUCTIONWIDTH-1:0] instruction,
    output logic [WIDTH-1:0]            PC,
    input  logic                        branchTaken,
    input  logic [WIDTH-1:0]            branchTarget,
    output logic                        halted
);

    logic [WIDTH-1:0] r_pcFetch;
    logic [WIDTH-1:0] r_respPC;
    logic             r_respValid;
    fetch_state_t     r_state;

    fetch_entry_t     w_wrEntry;
    fetch_entry_t     w_head;
    logic [1:0]       w_count;
    logic [2:0]       w_occ;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic             w_fetching;
    logic [OPCODEWIDTH-1:0] w_opcode;

    assign w_fetching = (r_state == FETCH);
    assign w_valid    = (w_count != 2'd0);
    assign w_pop      = w_valid & decodeReady;
    assign w_push     = r_respValid & w_fetching & ~branchTaken;
    assign w_opcode   = imemData[OPCODE_MSB:OPCODE_LSB];

    // Slots already spoken for: buffered words plus the read in flight.
    assign w_occ   = {1'b0, w_count} + {2'b00, r_respValid};
    assign w_issue = reset & w_fetching & ~branchTaken
                   & (w_occ < (3'd2 + {2'b00, w_pop}));

    assign w_wrEntry.instruction = imemData;
    assign w_wrEntry.address     = r_respPC;

    fetch_buffer u_buffer (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (branchTaken),
        .i_data  (w_wrEntry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pcFetch   <= WIDTH'(RESETPC);
            r_respPC    <= '0;
            r_respValid <= 1'b0;
            r_state     <= FETCH;
        end else if (branchTaken) begin
            r_pcFetch   <= branchTarget;
            r_respValid <= 1'b0;
            r_state     <= FETCH;
        end else begin
            r_respValid <= w_issue;
            if (w_issue) begin
                r_respPC  <= r_pcFetch;
                r_pcFetch <= r_pcFetch + WIDTH'(PCSTEP);
            end
            unique case (r_state)
                FETCH: begin
                    if (w_push && w_opcode == HALTOPCODE) begin
                        r_state <= HALTED;
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign imemAddress    = r_pcFetch;
    assign imemReadEnable = w_issue;
    assign instrValid     = w_valid;
    assign instruction    = w_valid ? w_head.instruction : '0;
    assign PC             = w_valid ? (w_head.address + WIDTH'(PCOFFSET)) : '0;
    assign halted         = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] imemAddress;
    logic        imemReadEnable;
    logic [23:0] imemData;
    logic        decodeReady;
    logic        instrValid;
    logic [23:0] instruction;
    logic [31:0] PC;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        halted;

    int nerr = 0;
    int nchk = 0;
    bit haltEn = 0;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .imemAddress    (imemAddress),
        .imemReadEnable (imemReadEnable),
        .imemData       (imemData),
        .decodeReady    (decodeReady),
        .instrValid     (instrValid),
        .instruction    (instruction),
        .PC             (PC),
        .branchTaken    (branchTaken),
        .branchTarget   (branchTarget),
        .halted         (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [23:0] word(input logic [31:0] a);
        if (haltEn && a == 32'h20) return 24'hF00000;
        return {4'h0, a[21:2]};
    endfunction

    initial imemData = '0;
    always @(posedge clock)
        if (imemReadEnable) imemData <= word(imemAddress);

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: addresses waiting for decode, one read in flight.
    logic [31:0] m_q[$];
    bit          m_fl;
    logic [31:0] m_flA;
    logic [31:0] m_pc;
    bit          m_halt;

    always @(negedge clock) begin
        bit          pop;
        bit          eRen;
        bit          eVal;
        int          occ;
        logic [31:0] head;
        if (!reset) begin
            m_q.delete();
            m_fl   = 0;
            m_flA  = 0;
            m_pc   = 0;
            m_halt = 0;
            chk("m_rst_valid", {31'd0, instrValid}, 0);
            chk("m_rst_ren", {31'd0, imemReadEnable}, 0);
            chk("m_rst_pc", PC, 0);
            chk("m_rst_instr", {8'd0, instruction}, 0);
            chk("m_rst_halted", {31'd0, halted}, 0);
            chk("m_rst_addr", imemAddress, 0);
        end else begin
            eVal = (m_q.size() > 0);
            head = eVal ? m_q[0] : 32'd0;
            pop  = eVal && decodeReady;
            occ  = m_q.size() + int'(m_fl) - int'(pop);
            eRen = !m_halt && !branchTaken && occ < 2;
            chk("m_valid", {31'd0, instrValid}, {31'd0, eVal});
            chk("m_instr", {8'd0, instruction}, eVal ? {8'd0, word(head)} : 32'd0);
            chk("m_pc", PC, eVal ? head + 32'd8 : 32'd0);
            chk("m_ren", {31'd0, imemReadEnable}, {31'd0, eRen});
            chk("m_addr", imemAddress, m_pc);
            chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
            if (branchTaken) begin
                m_q.delete();
                m_fl   = 0;
                m_pc   = branchTarget;
                m_halt = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_fl && !m_halt) begin
                    m_q.push_back(m_flA);
                    if (word(m_flA) >= 24'hF00000) m_halt = 1;
                end
                m_fl  = eRen;
                m_flA = m_pc;
                if (eRen) m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        decodeReady  = 1'b1;
        branchTaken  = 1'b0;
        branchTarget = '0;

        // Reset state and restart
        repeat (3) step();
        mid();
        chk("rst_valid", {31'd0, instrValid}, 0);
        chk("rst_ren", {31'd0, imemReadEnable}, 0);
        chk("rst_addr", imemAddress, 0);
        chk("rst_pc", PC, 0);
        step(); reset = 1'b1; mid();
        chk("t1_addr0", imemAddress, 32'h0);
        chk("t1_ren0", {31'd0, imemReadEnable}, 1);
        chk("t1_nvalid0", {31'd0, instrValid}, 0);
        step(); mid();
        chk("t1_addr1", imemAddress, 32'h4);
        chk("t1_nvalid1", {31'd0, instrValid}, 0);
        step(); mid();
        chk("t1_valid", {31'd0, instrValid}, 1);
        chk("t1_pc8", PC, 32'h8);
        chk("t1_i0", {8'd0, instruction}, 32'h0);
        step(); mid();
        chk("t1_pc12", PC, 32'hC);
        chk("t1_i1", {8'd0, instruction}, 32'h1);
        step(); mid();
        chk("t1_pc16", PC, 32'h10);
        step(); mid();
        chk("t1_pc20", PC, 32'h14);

        // Stall with head at 0x10
        step(); decodeReady = 1'b0; mid();
        chk("t2_head", PC, 32'h18);
        repeat (4) begin
            step(); mid();
            chk("t2_hold", PC, 32'h18);
            chk("t2_noren", {31'd0, imemReadEnable}, 0);
        end
        step(); decodeReady = 1'b1; mid();
        chk("t2_r0", PC, 32'h18);
        step(); mid();
        chk("t2_r1", PC, 32'h1C);
        step(); mid();
        chk("t2_r2", PC, 32'h20);

        // Redirect mid-stream
        step(); branchTaken = 1'b1; branchTarget = 32'h100; mid();
        chk("t3_noren", {31'd0, imemReadEnable}, 0);
        step(); branchTaken = 1'b0; mid();
        chk("t3_squash", {31'd0, instrValid}, 0);
        chk("t3_addr", imemAddress, 32'h100);
        chk("t3_ren", {31'd0, imemReadEnable}, 1);
        step(); mid();
        chk("t3_squash2", {31'd0, instrValid}, 0);
        step(); mid();
        chk("t3_valid", {31'd0, instrValid}, 1);
        chk("t3_pc", PC, 32'h108);
        chk("t3_instr", {8'd0, instruction}, 32'h40);

        // HALT word at 0x20
        step(); branchTaken = 1'b1; branchTarget = 32'h18; haltEn = 1; mid();
        step(); branchTaken = 1'b0; mid();
        chk("t4_addr", imemAddress, 32'h18);
        step(); mid();
        step(); mid();
        chk("t4_pc20", PC, 32'h20);
        step(); mid();
        chk("t4_pc24", PC, 32'h24);
        step(); mid();
        chk("t4_pc28", PC, 32'h28);
        chk("t4_halt_instr", {8'd0, instruction}, 32'hF00000);
        chk("t4_halted", {31'd0, halted}, 1);
        chk("t4_noren", {31'd0, imemReadEnable}, 0);
        repeat (3) begin
            step(); mid();
            chk("t4_drained", {31'd0, instrValid}, 0);
            chk("t4_still_halted", {31'd0, halted}, 1);
        end
        step(); branchTaken = 1'b1; branchTarget = 32'h40; mid();
        step(); branchTaken = 1'b0; mid();
        chk("t4_unhalt", {31'd0, halted}, 0);
        chk("t4_resume", imemAddress, 32'h40);
        step(); mid();
        step(); mid();
        chk("t4_pc48", PC, 32'h48);
        chk("t4_i48", {8'd0, instruction}, 32'h10);

        // Async reset with FIFO full
        step(); decodeReady = 1'b0;
        step();
        step(); mid();
        chk("t5_full", {31'd0, instrValid}, 1);
        step(); reset = 1'b0; haltEn = 0;
        #1;
        chk("t5_async_valid", {31'd0, instrValid}, 0);
        chk("t5_async_pc", PC, 0);
        chk("t5_async_instr", {8'd0, instruction}, 0);
        chk("t5_async_addr", imemAddress, 0);
        chk("t5_async_ren", {31'd0, imemReadEnable}, 0);
        decodeReady = 1'b1;
        step();
        step(); reset = 1'b1; mid();
        chk("t5_addr0", imemAddress, 0);
        chk("t5_ren", {31'd0, imemReadEnable}, 1);
        step(); mid();
        step(); mid();
        chk("t5_pc8", PC, 32'h8);

        // PC wrap
        step(); branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC; mid();
        step(); branchTaken = 1'b0; mid();
        chk("t6_addr", imemAddress, 32'hFFFF_FFFC);
        step(); mid();
        chk("t6_wrap", imemAddress, 32'h0);
        step(); mid();
        chk("t6_pc", PC, 32'h4);
        chk("t6_instr", {8'd0, instruction}, 32'hFFFFF);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
